// File: rtl/softmax_bwd_stream_if.sv
// Stream bundle for softmax_bwd_stream: (g_i, y_i, last, inv_sum) in, dx_i out.
interface softmax_bwd_stream_if #(
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_grad;
    logic [DATA_W-1:0] in_y;
    logic              in_last;
    logic [DATA_W-1:0] inv_sum;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_grad;
    logic              out_last;

    modport master (
        output in_valid, in_grad, in_y, in_last, inv_sum, out_ready,
        input  in_ready, out_valid, out_grad, out_last
    );

    modport slave (
        input  in_valid, in_grad, in_y, in_last, inv_sum, out_ready,
        output in_ready, out_valid, out_grad, out_last
    );
endinterface

// File: rtl/softmax_bwd_stream.sv
// Streaming backward pass of the sum normalizer: dx_i = (g_i - sum_j g_j*y_j) * inv_sum.
// Define SOFTMAX_BWD_SAT_EN to saturate the accumulator and dx instead of wrapping.
module softmax_bwd_stream #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned FRAC   = 12,
    parameter int unsigned MAX_N  = 64,
    parameter int unsigned ACC_W  = 40
) (
    input  logic                clk,
    input  logic                rst,
    softmax_bwd_stream_if.slave bus,
    output logic                busy,
    output logic                err_overflow
);
    localparam int unsigned PROD_W = ACC_W + DATA_W;
    localparam int unsigned GY_W   = 2 * DATA_W;
    localparam int unsigned CNT_W  = $clog2(MAX_N + 1);
    localparam int unsigned ADDR_W = $clog2(MAX_N);

    typedef enum logic [1:0] {ACCUM, DOT, DRAIN} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] gbuf [MAX_N];
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] inv_q;
    logic [CNT_W-1:0]         count;
    logic [CNT_W-1:0]         rd_ptr;

    logic                     accept_c;
    logic                     last_c;
    logic signed [GY_W-1:0]   gy_c;
    logic signed [ACC_W-1:0]  acc_next_c;
    logic signed [ACC_W-1:0]  dot_c;
    logic signed [ACC_W-1:0]  diff_c;
    logic [ADDR_W-1:0]        rd_idx_c;
    logic signed [PROD_W-1:0] prod_c;
    logic signed [PROD_W-1:0] res_c;
    logic signed [DATA_W-1:0] dx_c;

    assign accept_c = bus.in_valid && bus.in_ready;
    // A full buffer forces the current beat to close the vector.
    assign last_c   = bus.in_last || (count == CNT_W'(MAX_N - 1));
    assign gy_c     = GY_W'($signed(bus.in_grad)) * GY_W'($signed(bus.in_y));

`ifdef SOFTMAX_BWD_SAT_EN
    logic signed [ACC_W:0] sum_c;
    always_comb begin
        sum_c = (ACC_W+1)'(acc) + (ACC_W+1)'(gy_c);
        if (sum_c[ACC_W] != sum_c[ACC_W-1])
            acc_next_c = sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_next_c = sum_c[ACC_W-1:0];
    end
`else
    assign acc_next_c = acc + ACC_W'(gy_c);
`endif

    // Read index 0 during DOT so the first result is ready when DRAIN starts.
    assign rd_idx_c = (state == DRAIN) ? ADDR_W'(rd_ptr) : '0;
    assign dot_c    = acc >>> FRAC;
    assign diff_c   = ACC_W'(gbuf[rd_idx_c]) - dot_c;
    assign prod_c   = PROD_W'(diff_c) * PROD_W'(inv_q);
    assign res_c    = prod_c >>> FRAC;

`ifdef SOFTMAX_BWD_SAT_EN
    always_comb begin
        if (res_c[PROD_W-1:DATA_W-1] == {(PROD_W-DATA_W+1){res_c[PROD_W-1]}})
            dx_c = res_c[DATA_W-1:0];
        else
            dx_c = res_c[PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`else
    logic unused_res_hi;
    assign unused_res_hi = ^res_c[PROD_W-1:DATA_W];
    assign dx_c          = res_c[DATA_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (accept_c)
            gbuf[ADDR_W'(count)] <= $signed(bus.in_grad);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ACCUM;
            bus.in_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_grad <= '0;
            bus.out_last <= 1'b0;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
            acc          <= '0;
            count        <= '0;
            rd_ptr       <= '0;
            inv_q        <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        acc   <= acc_next_c;
                        count <= count + CNT_W'(1);
                        busy  <= 1'b1;
                        if (count == '0)
                            inv_q <= $signed(bus.inv_sum);
                        if (last_c) begin
                            state        <= DOT;
                            bus.in_ready <= 1'b0;
                            if (!bus.in_last)
                                err_overflow <= 1'b1;
                        end
                    end
                end
                DOT: begin
                    bus.out_valid <= 1'b1;
                    bus.out_grad  <= dx_c;
                    bus.out_last  <= (count == CNT_W'(1));
                    rd_ptr        <= CNT_W'(1);
                    state         <= DRAIN;
                end
                DRAIN: begin
                    // out_valid is always high here, so out_ready alone marks a handshake.
                    if (bus.out_ready) begin
                        if (bus.out_last) begin
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            busy          <= 1'b0;
                            acc           <= '0;
                            count         <= '0;
                            state         <= ACCUM;
                        end else begin
                            bus.out_grad <= dx_c;
                            bus.out_last <= (rd_ptr == count - CNT_W'(1));
                            rd_ptr       <= rd_ptr + CNT_W'(1);
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_softmax_bwd_stream.sv
// Testbench for softmax_bwd_stream: constant vector table, handwritten corner sequences,
// and randomized streams checked against an arithmetic reference model.
module tb_softmax_bwd_stream;
    localparam int DATA_W = 16;
    localparam int FRAC   = 12;
    localparam int MAX_N  = 64;
    localparam int ACC_W  = 40;

    typedef struct { int g; int y; int inv; bit last; } beat_t;
    typedef struct { int grad; bit last; } obeat_t;
    typedef struct { int n; int g[4]; int y[4]; int inv; int dx[4]; } tv_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err_overflow;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    beat_t  in_q[$];
    obeat_t out_q[$];
    obeat_t exp_q[$];
    int     in_hs[$];
    int     out_hs[$];
    int     stall_q[$];
    int     first_valid_cyc;
    int     ready_mode;
    bit     gaps;
    bit     inready_bad;
    tv_t    tbl[7];

    softmax_bwd_stream_if #(.DATA_W(DATA_W)) bus ();

    softmax_bwd_stream #(
        .DATA_W(DATA_W), .FRAC(FRAC), .MAX_N(MAX_N), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic longint sext(longint v, int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic longint clamp(longint v, int w);
        longint hi;
        longint lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic longint acc_add(longint a, longint p);
`ifdef SOFTMAX_BWD_SAT_EN
        return clamp(a + p, ACC_W);
`else
        return sext(a + p, ACC_W);
`endif
    endfunction

    function automatic longint fit_out(longint r);
`ifdef SOFTMAX_BWD_SAT_EN
        return clamp(r, DATA_W);
`else
        return sext(r, DATA_W);
`endif
    endfunction

    // Reference: split the beat list into vectors (in_last or MAX_N beats), then apply the formula.
    function automatic void model();
        int     i;
        int     inv;
        int     vg[$];
        int     vy[$];
        longint acc;
        longint dot;
        longint diff;
        longint res;
        exp_q.delete();
        i = 0;
        while (i < in_q.size()) begin
            vg.delete();
            vy.delete();
            inv = in_q[i].inv;
            acc = 0;
            forever begin
                vg.push_back(in_q[i].g);
                vy.push_back(in_q[i].y);
                i++;
                if (in_q[i-1].last || vg.size() == MAX_N || i == in_q.size()) break;
            end
            foreach (vg[k]) acc = acc_add(acc, longint'(vg[k]) * longint'(vy[k]));
            dot = acc >>> FRAC;
            foreach (vg[k]) begin
                diff = sext(longint'(vg[k]) - dot, ACC_W);
                res  = (diff * longint'(inv)) >>> FRAC;
                exp_q.push_back('{int'(fit_out(res)), k == vg.size() - 1});
            end
        end
    endfunction

    function automatic int rnd_val(bit wide);
        if (wide) return int'($signed(16'($urandom)));
        return int'($urandom_range(0, 8192)) - 4096;
    endfunction

    // Drives in_q and collects n_out output beats; both sides bounded by budget cycles.
    task automatic run(input int n_out, input int budget);
        int pat[4] = '{1, 0, 0, 1};
        out_q.delete();
        in_hs.delete();
        out_hs.delete();
        stall_q.delete();
        first_valid_cyc = -1;
        inready_bad = 1'b0;
        fork
            begin
                int idx = 0;
                int k = 0;
                while (idx < in_q.size() && k < budget) begin
                    if (gaps && $urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        bus.in_grad  = 16'($urandom);
                        bus.in_y     = 16'($urandom);
                        bus.in_last  = 1'($urandom);
                        bus.inv_sum  = 16'($urandom);
                    end else begin
                        bus.in_valid = 1'b1;
                        bus.in_grad  = 16'(in_q[idx].g);
                        bus.in_y     = 16'(in_q[idx].y);
                        bus.in_last  = in_q[idx].last;
                        bus.inv_sum  = 16'(in_q[idx].inv);
                    end
                    @(negedge clk);
                    if (bus.in_valid && bus.in_ready) begin
                        in_hs.push_back(cyc);
                        idx++;
                    end
                    @(posedge clk);
                    #1;
                    k++;
                end
                bus.in_valid = 1'b0;
            end
            begin
                int pi = 0;
                int k = 0;
                while (out_q.size() < n_out && k < budget) begin
                    if (ready_mode == 0) bus.out_ready = 1'b1;
                    else if (ready_mode == 1) bus.out_ready = 1'($urandom);
                    else if (in_hs.size() == in_q.size()) begin
                        bus.out_ready = (pi >= 4) || (pat[pi] != 0);
                        pi++;
                    end else bus.out_ready = 1'b0;
                    @(negedge clk);
                    if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                    if (bus.out_valid && bus.in_ready) inready_bad = 1'b1;
                    if (bus.out_valid && !bus.out_ready) stall_q.push_back(int'($signed(bus.out_grad)));
                    if (bus.out_valid && bus.out_ready) begin
                        out_q.push_back('{int'($signed(bus.out_grad)), bus.out_last});
                        out_hs.push_back(cyc);
                    end
                    @(posedge clk);
                    #1;
                    k++;
                end
                bus.out_ready = 1'b0;
            end
        join
        chk("inputs_taken", in_hs.size(), in_q.size());
        chk("outputs_seen", out_q.size(), n_out);
    endtask

    task automatic cmp_exp(input string tag);
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        foreach (exp_q[k]) begin
            if (k < out_q.size()) begin
                chk($sformatf("%s_grad[%0d]", tag, k), out_q[k].grad, exp_q[k].grad);
                chk($sformatf("%s_last[%0d]", tag, k), out_q[k].last, exp_q[k].last);
            end
        end
    endtask

    task automatic load_tv(input int t);
        in_q.delete();
        for (int j = 0; j < tbl[t].n; j++)
            in_q.push_back('{tbl[t].g[j], tbl[t].y[j],
                             (j == 0) ? tbl[t].inv : int'($urandom_range(0, 32767)),
                             j == tbl[t].n - 1});
    endtask

    initial begin
        tbl[0] = '{2, '{4096, 0, 0, 0}, '{1024, 3072, 0, 0}, 4096, '{3072, -1024, 0, 0}};
`ifdef SOFTMAX_BWD_SAT_EN
        tbl[1] = '{2, '{32767, -32768, 0, 0}, '{-4096, 0, 0, 0}, 4096, '{32767, -1, 0, 0}};
`else
        tbl[1] = '{2, '{32767, -32768, 0, 0}, '{-4096, 0, 0, 0}, 4096, '{-2, -1, 0, 0}};
`endif
        tbl[2] = '{1, '{4096, 0, 0, 0}, '{2048, 0, 0, 0}, 8192, '{4096, 0, 0, 0}};
        tbl[3] = '{1, '{8192, 0, 0, 0}, '{1024, 0, 0, 0}, 4096, '{6144, 0, 0, 0}};
        tbl[4] = '{1, '{-3, 0, 0, 0}, '{1, 0, 0, 0}, 4096, '{-2, 0, 0, 0}};
        tbl[5] = '{3, '{2048, -2048, 1024, 0}, '{2048, 1024, 1024, 0}, 8192, '{2560, -5632, 512, 0}};
        tbl[6] = '{2, '{1000, -500, 0, 0}, '{4096, 4096, 0, 0}, -4096, '{-500, 1000, 0, 0}};

        bus.in_valid = 1'b0;
        bus.in_grad = '0;
        bus.in_y = '0;
        bus.in_last = 1'b0;
        bus.inv_sum = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_grad", bus.out_grad, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overflow, 0);
        @(posedge clk);
        #1;

        // Constant vectors, out_ready held high.
        ready_mode = 0;
        gaps = 1'b0;
        for (int t = 0; t < 7; t++) begin
            load_tv(t);
            run(tbl[t].n, 200);
            for (int j = 0; j < tbl[t].n; j++) begin
                if (j < out_q.size()) begin
                    chk($sformatf("tv%0d_grad[%0d]", t, j), out_q[j].grad, tbl[t].dx[j]);
                    chk($sformatf("tv%0d_last[%0d]", t, j), out_q[j].last, j == tbl[t].n - 1);
                end
            end
            if (in_hs.size() > 0)
                chk($sformatf("tv%0d_latency", t), first_valid_cyc - in_hs[in_hs.size()-1], 2);
            chk($sformatf("tv%0d_in_ready_after", t), bus.in_ready, 1);
            chk($sformatf("tv%0d_busy_after", t), busy, 0);
        end

        // Stall on the first output beat: out_ready 1,0,0,1 from the DOT cycle on.
        load_tv(0);
        ready_mode = 2;
        run(2, 200);
        if (out_q.size() == 2) begin
            chk("stall_grad0", out_q[0].grad, 3072);
            chk("stall_grad1", out_q[1].grad, -1024);
            chk("stall_last1", out_q[1].last, 1);
        end
        chk("stall_cycles", stall_q.size(), 2);
        foreach (stall_q[k]) chk($sformatf("stall_hold[%0d]", k), stall_q[k], 3072);
        chk("stall_in_ready_low", inready_bad, 0);
        chk("stall_in_ready_after", bus.in_ready, 1);

        // Back-to-back vectors with in_valid held high.
        load_tv(0);
        for (int j = 0; j < 3; j++)
            in_q.push_back('{tbl[5].g[j], tbl[5].y[j], tbl[5].inv, j == 2});
        ready_mode = 0;
        model();
        run(exp_q.size(), 300);
        cmp_exp("b2b");
        if (in_hs.size() == 5 && out_hs.size() >= 2)
            chk("b2b_next_accept", in_hs[2], out_hs[1] + 1);

        // Randomized vectors with input gaps and random backpressure.
        in_q.delete();
        for (int v = 0; v < 25; v++) begin
            int n;
            bit wide;
            n = int'($urandom_range(1, 8));
            wide = 1'($urandom);
            for (int j = 0; j < n; j++)
                in_q.push_back('{rnd_val(wide), rnd_val(wide), rnd_val(wide), j == n - 1});
        end
        ready_mode = 1;
        gaps = 1'b1;
        model();
        run(exp_q.size(), 5000);
        cmp_exp("rand");
        chk("rand_in_ready_low", inready_bad, 0);

        // Overflow: MAX_N+3 beats, in_last only on the final one.
        in_q.delete();
        for (int j = 0; j < MAX_N + 3; j++)
            in_q.push_back('{rnd_val(1'b0), rnd_val(1'b0), rnd_val(1'b0), j == MAX_N + 2});
        chk("ovf_err_before", err_overflow, 0);
        ready_mode = 1;
        gaps = 1'b0;
        model();
        run(MAX_N + 3, 3000);
        cmp_exp("ovf");
        chk("ovf_err_after", err_overflow, 1);
        if (out_q.size() == MAX_N + 3) begin
            chk("ovf_last_at_max", out_q[MAX_N-1].last, 1);
            chk("ovf_notlast_before_max", out_q[MAX_N-2].last, 0);
            chk("ovf_second_vec_last", out_q[MAX_N+2].last, 1);
        end

        // Reset in the middle of DRAIN with the output stalled.
        bus.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            bus.in_valid = 1'b1;
            bus.in_grad  = 16'(tbl[5].g[j]);
            bus.in_y     = 16'(tbl[5].y[j]);
            bus.in_last  = (j == 2);
            bus.inv_sum  = 16'(tbl[5].inv);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        chk("mid_busy", busy, 1);
        for (int k = 0; k < 10 && !bus.out_valid; k++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_out_valid", bus.out_valid, 1);
        chk("mid_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_err", err_overflow, 0);
        @(posedge clk);
        #1;
        load_tv(2);
        ready_mode = 0;
        run(1, 200);
        if (out_q.size() == 1) begin
            chk("mrst_next_grad", out_q[0].grad, 4096);
            chk("mrst_next_last", out_q[0].last, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/softmax_bwd_stream.md
Name: softmax_bwd_stream

Overview:
- Backward-pass counterpart of the output-layer sum normalizer y_i = x_i / S.
- Takes the normalized outputs y_i and the upstream gradients g_i as a per-neuron stream.
- Returns the input gradients dx_i = (g_i - sum_j g_j*y_j) * inv_sum as a stream of equal length.
- Sits between the loss-gradient unit and the last-layer weight-update engine.

Parameters:
- DATA_W, 16, signed fixed-point width of g, y, inv_sum and dx (Q4.12 at defaults).
- FRAC, 12, fractional bits of every fixed-point operand.
- MAX_N, 64, maximum neurons per vector; gradient buffer depth.
- ACC_W, 40, signed width of the dot-product accumulator.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- in_grad  in  DATA_W  upstream gradient g_i, signed.
- in_y  in  DATA_W  normalized output y_i, signed.
- in_last  in  1  final neuron of the vector.
- inv_sum  in  DATA_W  1/S, signed; sampled on the first beat of each vector.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_grad  out  DATA_W  dx_i, signed.
- out_last  out  1  final output beat of the vector.
- busy  out  1  high from the first accepted input beat until the last output beat is accepted.
- err_overflow  out  1  sticky; vector exceeded MAX_N beats.

Behaviour:
- Reset values: in_ready=1; out_valid=0; out_grad=0; out_last=0; busy=0; err_overflow=0; accumulator=0; count=0; state=ACCUM.
- Clock/reset: one clock, clk; reset rst is synchronous and active-high. Reset mid-vector discards all buffered data and any pending output, and returns to ACCUM with in_ready=1 on the next cycle.
- ACCUM state:
  - in_ready=1.
  - On each handshake (in_valid & in_ready): write g_i to buffer[count], acc += g_i*y_i as a full 2*DATA_W product, sign-extended to ACC_W, count++.
  - inv_sum is latched on the beat with count==0.
- Transition to DOT: on the in_last handshake, or on the handshake with count==MAX_N-1 when in_last=0. In the latter case the beat is accepted, treated as last, and err_overflow is set (sticky until rst). Beats after a forced last belong to the next vector.
- DOT state (1 cycle):
  - in_ready=0.
  - dot = acc >>> FRAC (arithmetic shift, floor), kept at ACC_W.
  - Read pointer set to 0, buffer read issued.
- DRAIN state:
  - in_ready=0.
  - For each index i: diff = g_i - dot at ACC_W; prod = diff*inv_sum; res = prod >>> FRAC; res truncated to DATA_W (wrap), or saturated when the optional feature is enabled.
  - out_grad and out_last are registered. out_last=1 on index count-1.
  - First out_valid is asserted exactly 2 cycles after the cycle of the last input handshake.
  - With out_ready held 1, one beat per cycle.
  - While out_valid & !out_ready, out_grad and out_last hold stable and the pipeline stalls.
- End of vector: after the out_last handshake, acc and count clear and the state returns to ACCUM. in_ready=1 in the following cycle; no extra idle cycle.
- Single-neuron vector (in_last on the first beat) is legal: dx_0 = (g_0 - g_0*y_0)*inv_sum.
- in_grad, in_y and in_last are ignored when in_valid=0.

Optional Feature:
- Macro SOFTMAX_BWD_SAT_EN.
- Defined: res is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. acc saturates at ACC_W limits instead of wrapping.
- Undefined: res keeps its low DATA_W bits (two's-complement wrap). acc wraps.

Test Plan:
1. N=2, inv_sum=4096, y=[1024,3072], g=[4096,0] -> out_grad=[3072,-1024]; out_last on beat 2; first out_valid 2 cycles after the last input handshake.
2. Same vector, out_ready toggled 1,0,0,1 -> out_grad holds 3072 through the stall; no duplicated or lost beats; in_ready=0 until after the out_last handshake.
3. N=2, inv_sum=4096, g=[32767,-32768], y=[-4096,0] -> with SOFTMAX_BWD_SAT_EN: [32767,-1]; without: [-2,-1].
4. MAX_N+3 beats streamed with in_last=0 -> err_overflow=1 after beat MAX_N; exactly MAX_N outputs with out_last on the MAX_N-th; the remaining 3 beats form the next vector.
5. rst asserted mid-DRAIN -> next cycle out_valid=0, in_ready=1, busy=0, err_overflow=0; a subsequent N=1 vector with g=4096, y=2048, inv_sum=8192 gives out_grad=4096.
6. Two back-to-back vectors with in_valid held high -> second vector's first beat is accepted the cycle after the first vector's out_last handshake; both results are correct.
